// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the sequential multiply/divide controller.
//   state_e : controller FSM states
//   op_e    : operation selected on the accept edge
//   clog2   : ceiling log2, used to size the step counter as clog2(WIDTH+1)
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_e;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits = 0;
        while ((64'd1 << bits) < 64'(value)) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/multdiv_iter_core.sv
// Radix-2 iterative datapath shared by multiply and divide.
// A single 2*WIDTH register holds either the shift-add product accumulator (mul)
// or {remainder, quotient} for restoring division (div).
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   load           : capture magnitudes; acc becomes {0, mag_a}
//   op             : operation applied by each step
//   step           : perform one iteration
//   mag_a, mag_b   : unsigned operand magnitudes
//   acc            : product, or {remainder, quotient}
module multdiv_iter_core
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  op_e                op,
    input  logic               step,
    input  logic [WIDTH-1:0]   mag_a,
    input  logic [WIDTH-1:0]   mag_b,
    output logic [2*WIDTH-1:0] acc
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    always_comb begin
        acc_d   = acc_q;
        sum     = '0;
        shifted = '0;
        trial   = '0;
        if (load) begin
            acc_d = {{WIDTH{1'b0}}, mag_a};
        end else if (step) begin
            if (op == OP_MUL) begin
                // Add B into the upper half when the multiplier LSB is set, then shift right.
                sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end else begin
                // Shift the next dividend bit into the remainder; a borrow means restore.
                shifted = acc_q[2*WIDTH-1:WIDTH-1];
                trial   = shifted - {1'b0, b_q};
                if (!trial[WIDTH]) begin
                    acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            if (load) begin
                b_q <= mag_b;
            end
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Sequential multiply/divide controller for the execute stage.
// Accepts a one-cycle mul/div request, runs WIDTH radix-2 steps in multdiv_iter_core,
// applies sign correction and exception checks, then pulses multdiv_RDY for one cycle.
// Ports:
//   clock, reset_n            : clock and asynchronous active-low reset
//   mul, div, is_signed       : request strobes (mul wins) and signedness
//   data_operandA/B           : multiplicand/dividend, multiplier/divisor
//   multdiv_result/hi         : product low/high word, or quotient/remainder
//   multdiv_exception         : mul overflow, divide by zero, or signed MIN/-1
//   multdiv_RDY               : one-cycle result-valid pulse
//   busy                      : operation in flight; requests ignored
// Build option: MULTDIV_EARLY_TERM_EN lets B==0, B==1 or a zero multiplicand skip RUN.
module multdiv_seq_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             mul,
    input  logic             div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] multdiv_result,
    output logic [WIDTH-1:0] multdiv_hi,
    output logic             multdiv_exception,
    output logic             multdiv_RDY,
    output logic             busy
);

    localparam int unsigned CntW = clog2(WIDTH + 1);

    state_e             state_q;
    op_e                op_q;
    logic [CntW-1:0]    cnt_q;
    logic               signed_q, neg_lo_q, neg_hi_q, b_zero_q, ovf_q;

    logic               accept, skip_run, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc, prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_lo, fix_hi;
    logic               fix_exc;

    // DONE also accepts so back-to-back operations lose no cycle.
    assign accept = (mul | div) && (state_q == IDLE || state_q == DONE);
    assign a_neg  = is_signed & data_operandA[WIDTH-1];
    assign b_neg  = is_signed & data_operandB[WIDTH-1];
    assign mag_a  = a_neg ? -data_operandA : data_operandA;
    assign mag_b  = b_neg ? -data_operandB : data_operandB;

`ifdef MULTDIV_EARLY_TERM_EN
    // The freshly loaded accumulator {0, |A|} already holds the answer for these cases;
    // B==0 is overridden in FIX.
    assign skip_run = (data_operandB == '0) || (data_operandB == WIDTH'(1)) ||
                      (mul && data_operandA == '0);
`else
    assign skip_run = 1'b0;
`endif

    multdiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (accept),
        .op      (op_q),
        .step    (state_q == RUN),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .acc     (acc)
    );

    always_comb begin
        prod    = neg_lo_q ? -acc : acc;
        quo     = neg_lo_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem     = neg_hi_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_lo  = '0;
        fix_hi  = '0;
        fix_exc = 1'b0;
        if (b_zero_q) begin
            fix_exc = (op_q == OP_DIV);
        end else if (op_q == OP_MUL) begin
            fix_lo  = prod[WIDTH-1:0];
            fix_hi  = prod[2*WIDTH-1:WIDTH];
            fix_exc = signed_q ? (fix_hi != {WIDTH{fix_lo[WIDTH-1]}}) : (fix_hi != '0);
        end else begin
            fix_lo  = quo;
            fix_hi  = rem;
            fix_exc = ovf_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            op_q              <= OP_MUL;
            cnt_q             <= '0;
            signed_q          <= 1'b0;
            neg_lo_q          <= 1'b0;
            neg_hi_q          <= 1'b0;
            b_zero_q          <= 1'b0;
            ovf_q             <= 1'b0;
            multdiv_result    <= '0;
            multdiv_hi        <= '0;
            multdiv_exception <= 1'b0;
            multdiv_RDY       <= 1'b0;
            busy              <= 1'b0;
        end else begin
            multdiv_RDY <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q     <= mul ? OP_MUL : OP_DIV;
                        signed_q <= is_signed;
                        neg_lo_q <= a_neg ^ b_neg;
                        neg_hi_q <= a_neg;
                        b_zero_q <= (data_operandB == '0);
                        ovf_q    <= !mul && is_signed &&
                                    (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                    (data_operandB == '1);
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= skip_run ? FIX : RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    multdiv_result    <= fix_lo;
                    multdiv_hi        <= fix_hi;
                    multdiv_exception <= fix_exc;
                    multdiv_RDY       <= 1'b1;
                    state_q           <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
